// File: rtl/decoder_f_pkg.sv
// Shared widths and default minterm masks for the decoder-based function generator.
package decoder_f_pkg;

  localparam int SEL_W = 3;
  localparam int DEC_W = 8;

  // Bit k of a mask selects minterm k (s == k).
  // 8'h96 = minterms 1,2,4,7: odd parity, the full-adder sum.
  localparam logic [DEC_W-1:0] F1_MASK_DEF = 8'h96;
  // 8'hE8 = minterms 3,5,6,7: majority, the full-adder carry.
  localparam logic [DEC_W-1:0] F2_MASK_DEF = 8'hE8;
  // 8'h17 = minterms 0,1,2,4: at most one input high.
  localparam logic [DEC_W-1:0] F3_MASK_DEF = 8'h17;

endpackage

// File: rtl/decoder_f_decoder_3to8.sv
// Combinational 3-to-8 line decoder with enable. Output is one-hot or all-zero.
module decoder_3to8
  import decoder_f_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] s,
  output logic [DEC_W-1:0] y
);

  // Each minterm line is a full compare, so y can never be multi-hot.
  for (genvar k = 0; k < DEC_W; k++) begin : g_line
    assign y[k] = en && (s == SEL_W'(k));
  end

endmodule

// File: rtl/decoder_f.sv
// Function generator: decodes s into minterms, then ORs mask-selected minterms
// into f1/f2/f3. Outputs are optionally registered (one cycle of latency).
module decoder_f
  import decoder_f_pkg::*;
#(
  parameter logic [DEC_W-1:0] F1_MASK = F1_MASK_DEF,
  parameter logic [DEC_W-1:0] F2_MASK = F2_MASK_DEF,
  parameter logic [DEC_W-1:0] F3_MASK = F3_MASK_DEF,
  parameter bit               REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] s,
  output logic [DEC_W-1:0] dec,
  output logic             f1,
  output logic             f2,
  output logic             f3
);

  logic [DEC_W-1:0] dec_c;
  logic             f1_c, f2_c, f3_c;

  decoder_3to8 u_dec (
    .en (en),
    .s  (s),
    .y  (dec_c)
  );

  // A mask of 8'h00 yields constant 0; 8'hFF reduces to en.
  assign f1_c = |(dec_c & F1_MASK);
  assign f2_c = |(dec_c & F2_MASK);
  assign f3_c = |(dec_c & F3_MASK);

  if (REG_OUT) begin : g_reg
    // Output stage: capture decode and function terms; async clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dec <= '0;
        f1  <= 1'b0;
        f2  <= 1'b0;
        f3  <= 1'b0;
      end else begin
        dec <= dec_c;
        f1  <= f1_c;
        f2  <= f2_c;
        f3  <= f3_c;
      end
    end
  end else begin : g_comb
    // Zero-latency path; clock and reset have no effect here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dec = dec_c;
    assign f1  = f1_c;
    assign f2  = f2_c;
    assign f3  = f3_c;
  end

endmodule

// File: tb/tb_decoder_f.sv
// Directed, table-driven bench for decoder_f: registered default instance plus
// a combinational instance with F1_MASK=FF, F3_MASK=00.
module tb_decoder_f;

  logic       clk, rst_n, en;
  logic [2:0] s;
  logic [7:0] dec_r, dec_c;
  logic       f1_r, f2_r, f3_r, f1_c, f2_c, f3_c;

  int total = 0;
  int bad   = 0;

  decoder_f u_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s),
    .dec(dec_r), .f1(f1_r), .f2(f2_r), .f3(f3_r)
  );

  decoder_f #(.F1_MASK(8'hFF), .F3_MASK(8'h00), .REG_OUT(1'b0)) u_cmb (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s),
    .dec(dec_c), .f1(f1_c), .f2(f2_c), .f3(f3_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] s;
    logic [7:0] dec;
    logic       f1, f2, f3;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got dec/f1f2f3=%h want %h", nm, act, exp);
    end
  endtask

  // Sample one registered-output point one unit after the next rising edge.
  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hand-written truth table for the default masks (s: f1 f2 f3).
    vt[0]  = '{1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 3'd1, 8'h02, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 3'd3, 8'h08, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 3'd4, 8'h10, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 3'd5, 8'h20, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 3'd6, 8'h40, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 3'd7, 8'h80, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++)
      vt[8 + i] = '{1'b0, 3'(i), 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset held with en=1, s=7: outputs stay clear across edges.
    rst_n = 1'b0; en = 1'b1; s = 3'd7;
    for (int i = 0; i < 3; i++) begin
      edge_then_sample();
      chk("reset_hold", {dec_r, f1_r, f2_r, f3_r}, 11'h0);
    end
    #2 rst_n = 1'b1;
    edge_then_sample();
    chk("reset_release", {dec_r, f1_r, f2_r, f3_r}, {8'h80, 3'b110});

    // Table sweep: en=1 then en=0, each value held 5 cycles.
    for (int i = 0; i < 16; i++) begin
      en = vt[i].en; s = vt[i].s;
      #1;
      chk($sformatf("cmb_vec%0d", i), {dec_c, f1_c, f2_c, f3_c},
          {vt[i].dec, vt[i].en, vt[i].f2, 1'b0});
      edge_then_sample();
      chk($sformatf("reg_vec%0d", i), {dec_r, f1_r, f2_r, f3_r},
          {vt[i].dec, vt[i].f1, vt[i].f2, vt[i].f3});
      repeat (4) edge_then_sample();
      chk($sformatf("reg_hold%0d", i), {dec_r, f1_r, f2_r, f3_r},
          {vt[i].dec, vt[i].f1, vt[i].f2, vt[i].f3});
    end

    // Enable raise with s=0 (en currently 0, s=7).
    s = 3'd0;
    edge_then_sample();
    chk("en_low_s0", {dec_r, f1_r, f2_r, f3_r}, 11'h0);
    en = 1'b1;
    edge_then_sample();
    chk("en_raise_s0", {dec_r, f1_r, f2_r, f3_r}, {8'h01, 3'b001});

    // Latency: s 1 -> 6 just after an edge; old value visible until next edge.
    s = 3'd1;
    edge_then_sample();
    chk("lat_s1", {dec_r, f1_r, f2_r, f3_r}, {8'h02, 3'b101});
    s = 3'd6;
    #3;
    chk("lat_before_edge", {dec_r, f1_r, f2_r, f3_r}, {8'h02, 3'b101});
    chk("lat_cmb_now", {dec_c, f1_c, f2_c, f3_c}, {8'h40, 3'b110});
    edge_then_sample();
    chk("lat_after_edge", {dec_r, f1_r, f2_r, f3_r}, {8'h40, 3'b010});

    // Async reset mid-run with s=3.
    s = 3'd3;
    edge_then_sample();
    chk("ar_run", {dec_r, f1_r, f2_r, f3_r}, {8'h08, 3'b010});
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cleared", {dec_r, f1_r, f2_r, f3_r}, 11'h0);
    chk("ar_cmb_unaffected", {dec_c, f1_c, f2_c, f3_c}, {8'h08, 3'b110});
    #2 rst_n = 1'b1;
    edge_then_sample();
    chk("ar_reload", {dec_r, f1_r, f2_r, f3_r}, {8'h08, 3'b010});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_f.md
Name: decoder_f

Overview:
- Function generator built from a 3-to-8 line decoder plus OR-combining of selected minterms.
- Decodes a 3-bit select `s` into a one-hot minterm vector.
- Produces three Boolean functions f1, f2 and f3, each the OR of a parameterised minterm set.
- Used as a registered lookup-logic block; the defaults give full-adder sum and carry plus one auxiliary function.

Parameters:
- F1_MASK, default 8'h96, minterm set for f1: Σm(1,2,4,7), odd parity / adder sum.
- F2_MASK, default 8'hE8, minterm set for f2: Σm(3,5,6,7), majority / adder carry.
- F3_MASK, default 8'h17, minterm set for f3: Σm(0,1,2,4), at most one input high.
- REG_OUT, default 1: 1 = outputs registered, 1-cycle latency; 0 = combinational outputs, reset ignored on the output path.

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- en  input  1  decoder enable; when low, all minterm lines are 0
- s  input  3  select / function inputs; s[2] is MSB (variable A), s[0] is LSB (variable C)
- dec  output  8  one-hot minterm vector; dec[k] = 1 iff en=1 and s==k
- f1  output  1  OR of dec bits selected by F1_MASK
- f2  output  1  OR of dec bits selected by F2_MASK
- f3  output  1  OR of dec bits selected by F3_MASK

Behaviour:
- Reset: asserting rst_n=0 immediately (asynchronously) forces dec=8'h00 and f1=f2=f3=0.
- Reset release: the first capture occurs on the first rising clk edge with rst_n=1.
- Combinational core: dec_c = en ? (8'b1 << s) : 8'h00.
- Function terms: fN_c = |(dec_c & FN_MASK).
- REG_OUT=1: on each rising clk, dec <= dec_c and fN <= fN_c. Outputs reflect the s/en sampled at the previous edge, i.e. latency of exactly 1 cycle.
- REG_OUT=0: outputs equal the combinational values directly, with zero latency. clk and rst_n are unused on this path.
- en=0: dec=0 and all f outputs are 0 regardless of s, including minterms that appear in a mask (e.g. s=0 with F3_MASK).
- Invariant: dec is always one-hot or all-zero, never multi-hot.
- s is fully decoded; there are no illegal or X-propagating codes. Each s value 0..7 maps to exactly one dec bit.
- Reset mid-operation: outputs clear asynchronously. Resuming from reset needs no flush; the next edge reloads from the current s/en.
- A mask of 8'h00 yields a constant-0 output; a mask of 8'hFF yields an output equal to en (registered when REG_OUT=1).
- Default truth table, s: f1 f2 f3
  - 0: 0 0 1
  - 1: 1 0 1
  - 2: 1 0 1
  - 3: 0 1 0
  - 4: 1 0 1
  - 5: 0 1 0
  - 6: 0 1 0
  - 7: 1 1 0

Decomposition:
- Package decoder_f_pkg holds:
  - the default mask constants F1_MASK_DEF, F2_MASK_DEF, F3_MASK_DEF;
  - a localparam for the select width (3) and the decoded width (8).
- Sub-module decoder_3to8: purely combinational, inputs en and s[2:0], output y[7:0] one-hot.
- decoder_f instantiates decoder_3to8 once. The mask-OR logic and the output register stage stay in the top.

Test Plan:
- Reset check: hold rst_n=0 with en=1, s=3'd7 -> dec=8'h00 and f1=f2=f3=0 at all times. After release, one edge later -> dec=8'h80 and f1=1, f2=1, f3=0.
- Exhaustive sweep: en=1, s stepped 0..7 holding each value 5 cycles -> one cycle after each change, dec=1<<s and f1/f2/f3 match the default truth table (e.g. s=5 gives dec=8'h20, f1=0, f2=1, f3=0).
- Enable gating: en=0 while sweeping s=0..7 -> dec=8'h00 and f1=f2=f3=0 for every s. Raising en with s=0 -> next cycle dec=8'h01 and f3=1.
- Asynchronous reset mid-run: s=3'd3, en=1 running, pull rst_n low between clock edges -> outputs clear before the next edge. After release, reload gives f2=1 only.
- Latency check: change s from 1 to 6 just after an edge -> outputs still show s=1 values (f1=1, f3=1) until the next edge, then f2=1 only.
- Parameter and mode variant: F1_MASK=8'hFF, F3_MASK=8'h00, REG_OUT=0 -> f1 equals en combinationally, f3 stays 0, and dec follows s with zero latency.
